alu_top: RTL and testbench

ALU_TOP -- requirements
Module: alu_top

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_core.sv | 48 ++++
 rtl/alu_top.sv | 44 ++++
 tb/tb_alu_top.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and default widths for the registered ALU.
package alu_pkg;

  localparam int unsigned SIZE_DEFAULT = 4;
  localparam int unsigned N_DEFAULT    = 3;

  localparam int unsigned OP_MOV = 0;
  localparam int unsigned OP_NOT = 1;
  localparam int unsigned OP_ADD = 2;
  localparam int unsigned OP_SUB = 3;
  localparam int unsigned OP_OR  = 4;
  localparam int unsigned OP_AND = 5;
  localparam int unsigned OP_SLI = 6;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: operands and opcode in, result and carry/borrow out.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned size = SIZE_DEFAULT,
  parameter int unsigned n    = N_DEFAULT
) (
  input  logic [size-1:0] a_i,
  input  logic [size-1:0] b_i,
  input  logic [n-1:0]    select_i,
  output logic [size-1:0] result_o,
  output logic            carry_o
);

  logic [size:0] sum;
  logic [size:0] diff;
  logic          signed_lt;

  // Widened by one bit so the top bit carries out (ADD) or borrows (SUB).
  assign sum       = {1'b0, a_i} + {1'b0, b_i};
  assign diff      = {1'b0, a_i} - {1'b0, b_i};
  assign signed_lt = $signed(a_i) < $signed(b_i);

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    case (32'(select_i))
      OP_MOV: result_o = a_i;
      OP_NOT: result_o = ~a_i;
      OP_ADD: begin
        result_o = sum[size-1:0];
        carry_o  = sum[size];
      end
      OP_SUB: begin
        result_o = diff[size-1:0];
        carry_o  = diff[size];
      end
      OP_OR:  result_o = a_i | b_i;
      OP_AND: result_o = a_i & b_i;
      OP_SLI: result_o[0] = signed_lt;
      default: begin
        result_o = '0;
        carry_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_top.sv
// Registered ALU: combinational alu_core followed by a one-cycle output register.
module alu_top
  import alu_pkg::*;
#(
  parameter int unsigned size = SIZE_DEFAULT,
  parameter int unsigned n    = N_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [size-1:0] R2,
  input  logic [size-1:0] R3,
  input  logic [n-1:0]    select,
  output logic [size-1:0] R0,
  output logic            R0_carry
);

  logic [size-1:0] r0_d, r0_q;
  logic            carry_d, carry_q;

  alu_core #(
    .size (size),
    .n    (n)
  ) u_alu_core (
    .a_i      (R2),
    .b_i      (R3),
    .select_i (select),
    .result_o (r0_d),
    .carry_o  (carry_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      r0_q    <= r0_d;
      carry_q <= carry_d;
    end
  end

  assign R0       = r0_q;
  assign R0_carry = carry_q;

endmodule

// File: tb/tb_alu_top.sv
// Self-checking bench for alu_top: integer reference model plus literal spot checks.
module tb_alu_top;
  import alu_pkg::*;

  localparam int SIZE = 4;
  localparam int N    = 3;
  localparam int MOD  = 1 << SIZE;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [SIZE-1:0] R2 = '0;
  logic [SIZE-1:0] R3 = '0;
  logic [N-1:0]    select = '0;
  logic [SIZE-1:0] R0;
  logic            R0_carry;

  int vectors = 0;
  int miscompares = 0;
  int exp_r = 0;
  int exp_c = 0;

  alu_top #(
    .size (SIZE),
    .n    (N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .R2       (R2),
    .R3       (R3),
    .select   (select),
    .R0       (R0),
    .R0_carry (R0_carry)
  );

  always #5 clk = ~clk;

  function automatic int to_signed(input int v);
    return (v >= MOD / 2) ? v - MOD : v;
  endfunction

  // Reference behaviour straight from the opcode table, using plain integers.
  function automatic void model(input int a, input int b, input int sel,
                                output int r, output int c);
    r = 0;
    c = 0;
    case (sel)
      0: r = a;
      1: r = (MOD - 1) - a;
      2: begin r = (a + b) % MOD; c = (a + b >= MOD) ? 1 : 0; end
      3: begin r = (a - b + MOD) % MOD; c = (a < b) ? 1 : 0; end
      4: r = a | b;
      5: r = a & b;
      6: r = (to_signed(a) < to_signed(b)) ? 1 : 0;
      default: r = 0;
    endcase
  endfunction

  // Registered expectation: what R0/R0_carry must hold after each edge.
  always @(posedge clk or negedge rst_n) begin
    int r, c;
    if (!rst_n) begin
      exp_r = 0;
      exp_c = 0;
    end else begin
      model(int'(R2), int'(R3), int'(select), r, c);
      exp_r = r;
      exp_c = c;
    end
  end

  always @(negedge clk) begin
    vectors++;
    if (int'(R0) != exp_r || int'(R0_carry) != exp_c) begin
      miscompares++;
      $display("FAIL model t=%0t: R0=%0d carry=%0d, required R0=%0d carry=%0d",
               $time, R0, R0_carry, exp_r, exp_c);
    end
  end

  task automatic check_lit(input string name, input int r, input int c);
    vectors++;
    if (int'(R0) != r || int'(R0_carry) != c) begin
      miscompares++;
      $display("FAIL %s: R0=%0d carry=%0d, required R0=%0d carry=%0d",
               name, R0, R0_carry, r, c);
    end
  endtask

  task automatic apply(input int sel, input int a, input int b);
    @(negedge clk);
    #1;
    select = N'(sel);
    R2     = SIZE'(a);
    R3     = SIZE'(b);
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int sel, input int a, input int b,
                     input int r, input int c);
    apply(sel, a, b);
    check_lit(name, r, c);
  endtask

  initial begin
    #3;
    check_lit("reset_state", 0, 0);
    @(posedge clk);
    #1;
    check_lit("reset_hold", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    lit("add_15_15", OP_ADD, 15, 15, 14, 1);
    lit("add_m1_1",  OP_ADD, 15, 1,  0,  1);
    lit("add_m4_10", OP_ADD, 12, 10, 6,  1);
    lit("sub_15_10", OP_SUB, 15, 10, 5,  0);
    lit("sub_10_15", OP_SUB, 10, 15, 11, 1);
    lit("sub_0_15",  OP_SUB, 0,  15, 1,  1);
    lit("sub_15_15", OP_SUB, 15, 15, 0,  0);
    lit("mov_6_5",   OP_MOV, 6,  5,  6,  0);
    lit("not_6",     OP_NOT, 6,  5,  9,  0);
    lit("or_10_15",  OP_OR,  10, 15, 15, 0);
    lit("and_10_15", OP_AND, 10, 15, 10, 0);
    lit("op7_zero",  7,      15, 15, 0,  0);
    lit("sli_m1_5",  OP_SLI, 15, 5,  1,  0);
    lit("sli_1_m1",  OP_SLI, 1,  15, 0,  0);
    lit("sli_m5_m1", OP_SLI, 11, 15, 1,  0);
    lit("sli_m1_m5", OP_SLI, 15, 11, 0,  0);
    lit("sli_eq0",   OP_SLI, 0,  0,  0,  0);
    lit("sli_eq1",   OP_SLI, 1,  1,  0,  0);
    lit("sli_eqm1",  OP_SLI, 15, 15, 0,  0);
    lit("sli_0_m1",  OP_SLI, 0,  15, 0,  0);
    lit("sli_0_1",   OP_SLI, 0,  1,  1,  0);
    lit("sli_m1_0",  OP_SLI, 15, 0,  1,  0);

    // Mid-cycle input change must not disturb the registered output.
    lit("latency_load", OP_ADD, 3, 4, 7, 0);
    #1;
    R2 = 4'd9;
    R3 = 4'd9;
    #2;
    check_lit("latency_hold", 7, 0);
    @(posedge clk);
    #1;
    check_lit("latency_next", 2, 1);

    // Asynchronous reset between edges, held across edges, then released.
    lit("rst_preload", OP_ADD, 15, 15, 14, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_lit("rst_immediate", 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_lit("rst_held", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_lit("rst_released_pre_edge", 0, 0);
    @(posedge clk);
    #1;
    check_lit("rst_reload", 14, 1);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      select = N'($urandom_range(0, 7));
      R2     = SIZE'($urandom);
      R3     = SIZE'($urandom);
    end
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
